flags_register_stack: RTL and testbench

- Parametrised successor to the calculator's single flags register.
- Holds the status word (NZCV in the top nibble by default) with a per-bit write mask.
- Adds a DEPTH-entry save/restore stack for nested operations and an ARM condition-code evaluator that drives conditional execution in the datapath.
- Sits between the ALU flag outputs and the control unit.

---
 rtl/flags_register_stack.sv | 133 +++++++++++++
 tb/tb_flags_register_stack.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/flags_register_stack.sv
// Status word with a per-bit write mask, a DEPTH-entry save/restore stack and an
// ARM condition-code evaluator driven from the registered NZCV flags.
module flags_register_stack #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int FLAG_LSB = 28
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           Di,
    input  logic                       enable,
    input  logic [WIDTH-1:0]           mask,
    input  logic                       push,
    input  logic                       pop,
    input  logic [3:0]                 cond,
    output logic [WIDTH-1:0]           Do,
    output logic                       cond_pass,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);

    logic [WIDTH-1:0] do_q;
    logic [WIDTH-1:0] do_next;
    logic [WIDTH-1:0] wr_val;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [DW-1:0]    depth_q;
    logic [DW-1:0]    depth_next;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    push_idx;
    logic             ovf_q;
    logic             unf_q;
    logic             is_empty;
    logic             is_full;
    logic             do_restore;
    logic             do_swap;
    logic             do_push;
    logic             ovf_set;
    logic             unf_set;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DEPTH_V);
    assign top_idx  = AW'(depth_q - DW'(1));
    assign push_idx = AW'(depth_q);
    assign wr_val   = (do_q & ~mask) | (Di & mask);

    // Pop (and swap) win over push; push+pop on an empty stack degrades to a plain push.
    assign do_restore = pop && !is_empty;
    assign do_swap    = do_restore && push;
    assign do_push    = push && !do_restore && !is_full;
    assign ovf_set    = push && !pop && is_full;
    assign unf_set    = pop && !push && is_empty;

    always_comb begin
        do_next    = do_q;
        depth_next = depth_q;
        if (do_restore) begin
            do_next = stack_q[top_idx];
        end else if (!enable) begin
            do_next = wr_val;
        end
        if (do_push) begin
            depth_next = depth_q + DW'(1);
        end else if (do_restore && !do_swap) begin
            depth_next = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            do_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            do_q    <= do_next;
            depth_q <= depth_next;
            if (ovf_set) ovf_q <= 1'b1;
            if (unf_set) unf_q <= 1'b1;
            // The pre-write Do is what gets saved, both on push and on swap.
            if (do_push) begin
                stack_q[push_idx] <= do_q;
            end else if (do_swap) begin
                stack_q[top_idx] <= do_q;
            end
        end
    end

    assign flag_v = do_q[FLAG_LSB];
    assign flag_c = do_q[FLAG_LSB+1];
    assign flag_z = do_q[FLAG_LSB+2];
    assign flag_n = do_q[FLAG_LSB+3];

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign Do      = do_q;
    assign depth   = depth_q;
    assign full    = is_full;
    assign empty   = is_empty;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule

// File: tb/tb_flags_register_stack.sv
// Directed bench for flags_register_stack: expected values go into a queue as
// stimulus is driven and are popped when the corresponding output is sampled.
module tb_flags_register_stack;

    logic        clk;
    logic        rst;
    logic [31:0] Di;
    logic        enable;
    logic [31:0] mask;
    logic        push;
    logic        pop;
    logic [3:0]  cond;
    logic [31:0] Do;
    logic        cond_pass;
    logic [2:0]  depth;
    logic        full;
    logic        empty;
    logic        ovf_err;
    logic        unf_err;

    logic [31:0] exp_q[$];
    int          n_cmp;
    int          n_fail;

    flags_register_stack #(.WIDTH(32), .DEPTH(4), .FLAG_LSB(28)) dut (
        .clk(clk), .rst(rst), .Di(Di), .enable(enable), .mask(mask),
        .push(push), .pop(pop), .cond(cond), .Do(Do), .cond_pass(cond_pass),
        .depth(depth), .full(full), .empty(empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference condition table
    function automatic logic cond_model(input logic [3:0] nzcv, input logic [3:0] c);
        logic n, z, cf, v;
        n = nzcv[3]; z = nzcv[2]; cf = nzcv[1]; v = nzcv[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf & !z;
            4'h9: return !cf | z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // driver tasks
    task automatic idle();
        Di = '0; enable = 1'b1; mask = '0; push = 1'b0; pop = 1'b0; rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
    endtask

    task automatic write(input logic [31:0] d, input logic [31:0] m);
        Di = d; mask = m; enable = 1'b0;
        step();
    endtask

    // scoreboard
    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        exp_v = 'x;
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_do, input logic [2:0] e_depth,
                               input logic e_ovf, input logic e_unf);
        logic e_full, e_empty;
        e_full  = (e_depth == 3'd4);
        e_empty = (e_depth == 3'd0);
        expect_val(e_do);
        check({tag, ".Do"}, Do);
        expect_val({25'b0, e_depth, e_full, e_empty, e_ovf, e_unf});
        check({tag, ".stat"}, {25'b0, depth, full, empty, ovf_err, unf_err});
    endtask

    task automatic check_cond(input string tag, input logic [3:0] c, input logic e);
        cond = c;
        #1;
        expect_val({31'b0, e});
        check(tag, {31'b0, cond_pass});
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        idle();
        cond = 4'hE;

        // reset then write
        do_reset();
        do_reset();
        check_state("reset", 32'h0, 3'd0, 1'b0, 1'b0);
        check_cond("reset_al", 4'hE, 1'b1);
        write(32'hA000_0005, 32'hFFFF_FFFF);
        check_state("write_full", 32'hA000_0005, 3'd0, 1'b0, 1'b0);
        check_cond("write_mi", 4'h4, 1'b1);
        check_cond("write_eq", 4'h0, 1'b0);

        // masked update
        write(32'h4000_0000, 32'hF000_0000);
        check_state("masked", 32'h4000_0005, 3'd0, 1'b0, 1'b0);
        check_cond("masked_eq", 4'h0, 1'b1);
        check_cond("masked_hi", 4'h8, 1'b0);

        // nesting
        write(32'h1000_0000, 32'hFFFF_FFFF);
        push = 1'b1; step();
        write(32'h2000_0000, 32'hFFFF_FFFF);
        push = 1'b1; step();
        write(32'h8000_0000, 32'hFFFF_FFFF);
        check_state("nest_top", 32'h8000_0000, 3'd2, 1'b0, 1'b0);
        pop = 1'b1; step();
        check_state("nest_pop1", 32'h2000_0000, 3'd1, 1'b0, 1'b0);
        pop = 1'b1; step();
        check_state("nest_pop2", 32'h1000_0000, 3'd0, 1'b0, 1'b0);

        // overflow: each push also loads i+1, so the saved sequence is 10000000,1,2,3
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; enable = 1'b0; mask = 32'hFFFF_FFFF; Di = 32'(i + 1);
            step();
        end
        check_state("ovf", 32'h5, 3'd4, 1'b1, 1'b0);
        pop = 1'b1; step();
        check_state("ovf_pop1", 32'h3, 3'd3, 1'b1, 1'b0);
        pop = 1'b1; step();
        check_state("ovf_pop2", 32'h2, 3'd2, 1'b1, 1'b0);
        pop = 1'b1; step();
        check_state("ovf_pop3", 32'h1, 3'd1, 1'b1, 1'b0);
        pop = 1'b1; step();
        check_state("ovf_pop4", 32'h1000_0000, 3'd0, 1'b1, 1'b0);
        pop = 1'b1; step();
        check_state("unf", 32'h1000_0000, 3'd0, 1'b1, 1'b1);
        do_reset();
        check_state("err_clear", 32'h0, 3'd0, 1'b0, 1'b0);

        // simultaneous events
        write(32'hC000_0000, 32'hFFFF_FFFF);
        push = 1'b1; enable = 1'b0; mask = 32'hFFFF_FFFF; Di = 32'h3000_0000;
        step();
        check_state("push_wr", 32'h3000_0000, 3'd1, 1'b0, 1'b0);
        push = 1'b1; pop = 1'b1; enable = 1'b0; mask = 32'hFFFF_FFFF; Di = 32'h0BAD_0000;
        step();
        check_state("swap", 32'hC000_0000, 3'd1, 1'b0, 1'b0);
        pop = 1'b1; enable = 1'b0; mask = 32'hFFFF_FFFF; Di = 32'h1234_5678;
        step();
        check_state("pop_wr", 32'h3000_0000, 3'd0, 1'b0, 1'b0);
        push = 1'b1; pop = 1'b1; enable = 1'b0; mask = 32'h0000_00FF; Di = 32'h0000_0055;
        step();
        check_state("pp_empty", 32'h3000_0055, 3'd1, 1'b0, 1'b0);
        pop = 1'b1; step();
        check_state("pp_empty_pop", 32'h3000_0000, 3'd0, 1'b0, 1'b0);
        write(32'h7000_0000, 32'hFFFF_FFFF);
        push = 1'b1; push = 1'b1; step();
        rst = 1'b1; push = 1'b1; enable = 1'b0; mask = 32'hFFFF_FFFF; Di = 32'hFFFF_FFFF;
        step();
        check_state("rst_prio", 32'h0, 3'd0, 1'b0, 1'b0);

        // condition sweep
        for (int f = 0; f < 16; f++) begin
            write({4'(f), 28'h0}, 32'hFFFF_FFFF);
            for (int c = 0; c < 16; c++) begin
                check_cond($sformatf("cond_f%0h_c%0h", f, c), 4'(c), cond_model(4'(f), 4'(c)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
